ifetch_stream: RTL and testbench
================================

Name: ifetch_stream

Overview:
- Parametrised instruction-fetch sequencer for the MIPS datapath.
- Generates the PC sequence autonomously: PC+STEP stepping, branch/jump redirect, decoder back-pressure.
- Drives a synchronous instruction ROM with 1-cycle read latency.
- Presents each instruction with its PC and opcode/funct fields to the controller over a valid/ready handshake.

Parameters:
- ADDR_W, 32, width of PC and ROM address.
- RESET_PC, 0, first fetch address after reset; must be STEP-aligned.
- STEP, 4, byte increment between sequential fetches; power of two, at most 2^ADDR_W/2.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- imem_en  out  1  ROM read enable; one fetch issued per cycle it is high
- imem_addr  out  ADDR_W  ROM address; valid when imem_en=1
- imem_rdata  in  32  ROM data; valid the cycle after an issued fetch
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  ADDR_W  target address
- out_valid  out  1  instruction available
- out_ready  in  1  consumer accepts when out_valid&out_ready
- out_instr  out  32  instruction word
- out_pc  out  ADDR_W  address of out_instr
- out_op  out  6  out_instr[31:26]
- out_funct  out  6  out_instr[5:0]
- misalign  out  1  one-cycle pulse: redirect rejected, target not STEP-aligned

Behaviour:
- Reset (rst=0, immediate, no clock needed): state=BOOT, pc=RESET_PC, inflight=0, hold_valid=0, misalign=0. Hence imem_en=0 and out_valid=0.
- Reset mid-stream: in-flight and held data are lost. Refetch starts at RESET_PC.
- State BOOT: no issue. Next edge -> RUN. First imem_en=1 falls in the 1st cycle after rst deasserts.
- State RUN:
  - issue = (out_ready | (~hold_valid & ~inflight)) & ~redirect_accept.
  - imem_addr = pc.
  - On issue: pc <= pc+STEP (mod 2^ADDR_W; wraps to 0), inflight <= 1, inflight_pc <= pc.
  - Without issue and without redirect: inflight <= 0 once its response is consumed or moved to hold.
  - RUN is never left except by reset.
- Output mux:
  - out_valid = hold_valid | inflight.
  - out_instr/out_pc = hold_valid ? hold_instr/hold_pc : imem_rdata/inflight_pc.
  - Combinational from imem_rdata, so fetch-to-out_valid latency = 1 cycle.
  - Sustained throughput is 1 instruction/cycle while out_ready=1.
- Back-pressure:
  - inflight & ~hold_valid & ~out_ready: the response is captured into hold at the edge, and no new issue occurs that cycle.
  - hold_valid & out_ready: hold drains that edge; an issue in the same cycle is permitted.
  - Hold depth is exactly 1. No instruction is ever dropped or duplicated without a redirect.
  - out_instr/out_pc remain stable while out_valid & ~out_ready.
- Redirect:
  - redirect_accept = redirect_valid & (redirect_pc mod STEP == 0).
  - When accepted: out_valid forced 0 that cycle; inflight and hold discarded (both cleared); no issue; pc <= redirect_pc.
  - The target is issued the next cycle and appears on out the cycle after (2-cycle redirect penalty).
  - Redirect overrides back-pressure and issue in the same cycle.
- Misaligned redirect: ignored entirely (stream continues as if absent); misalign=1 for that one cycle (registered, visible next cycle).
- Redirect during BOOT: accepted. pc <= redirect_pc; first issue uses the redirect target.

Decomposition:
- Package ifetch_pkg:
  - state encoding BOOT/RUN
  - OP_LSB=26, OP_W=6, FUNCT_W=6, INSTR_W=32 field constants
- Natural sub-module: ifetch_skid, a 1-entry hold buffer holding {instr,pc} with load/drain controls. The PC/FSM logic stays in the top.

Test Plan:
- Reset/boot: ROM word[A]=A, rst low for 3 cycles then high, out_ready=1. Required: imem_en=0 throughout reset; first imem_addr=0 in cycle 1 after release; out_pc/out_instr sequence 0,4,8,12,16,20 on consecutive cycles.
- Stall: out_ready=0 for 3 cycles while out_pc=8. Required: out_instr stays 8; exactly one fetch (addr 12) is issued; on release the stream is 8,12,16 with no gaps or duplicates.
- Redirect: redirect_valid=1, redirect_pc=0x40 while out_pc=12. Required: out_valid=0 that cycle and the next; next accepted out_pc=0x40; instructions 16 and 20 are never presented.
- Misaligned redirect: redirect_pc=0x42. Required: misalign pulses for 1 cycle and the stream continues unbroken. Repeat with STEP=8, redirect_pc=0x44: rejected.
- Wrap: ADDR_W=8, RESET_PC=0xF8. Required: out_pc 0xF8,0xFC,0x00,0x04.
- Async reset mid-stall: hold_valid=1 and rst dropped between clock edges. Required: out_valid=0 immediately; after release the stream restarts at RESET_PC.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and instruction field constants for the fetch sequencer.
// Pure declarations: no latency, no flow control.
// Imported by ifetch_stream and ifetch_skid.
package ifetch_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int INSTR_W = 32;
    localparam int OP_LSB  = 26;
    localparam int OP_W    = 6;
    localparam int FUNCT_W = 6;

endpackage

// File: rtl/ifetch_skid.sv
// One-entry hold register for an {instr, pc} pair the consumer could not take.
// Latency: loaded value visible the cycle after load.
// Backpressure: holds until drain; flush discards and wins over load and drain.
module ifetch_skid
    import ifetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               drain,
    input  logic               flush,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [ADDR_W-1:0]  in_pc,
    output logic               hold_valid,
    output logic [INSTR_W-1:0] hold_instr,
    output logic [ADDR_W-1:0]  hold_pc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_valid <= 1'b0;
            hold_instr <= '0;
            hold_pc    <= '0;
        end else if (flush) begin
            hold_valid <= 1'b0;
        end else if (load) begin
            hold_valid <= 1'b1;
            hold_instr <= in_instr;
            hold_pc    <= in_pc;
        end else if (drain) begin
            hold_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ifetch_stream.sv
// Instruction-fetch sequencer: steps the PC, drives a 1-cycle ROM, handles redirects.
// Latency: fetch to out_valid 1 cycle; accepted redirect to target on out 2 cycles.
// Backpressure: a stalled response parks in a 1-entry skid and issue pauses until drained.
module ifetch_stream
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                STEP     = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [OP_W-1:0]    out_op,
    output logic [FUNCT_W-1:0] out_funct,
    output logic               misalign
);

    localparam logic [ADDR_W-1:0] STEP_V    = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] STEP_MASK = ADDR_W'(STEP - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                inflight_q, inflight_d;
    logic [ADDR_W-1:0]   inflight_pc_q, inflight_pc_d;
    logic                misalign_q;

    logic                run;
    logic                aligned;
    logic                redirect_accept;
    logic                issue;
    logic                skid_load;
    logic                skid_drain;
    logic                hold_valid;
    logic [INSTR_W-1:0]  hold_instr;
    logic [ADDR_W-1:0]   hold_pc;

    assign run             = (state_q == RUN);
    assign aligned         = (redirect_pc & STEP_MASK) == '0;
    assign redirect_accept = redirect_valid & aligned;

    // A response only parks in the skid when nobody takes it; issue is held off then
    // so the skid never has to absorb a second word.
    assign issue      = run & (out_ready | (~hold_valid & ~inflight_q)) & ~redirect_accept;
    assign skid_load  = run & inflight_q & ~hold_valid & ~out_ready & ~redirect_accept;
    assign skid_drain = hold_valid & out_ready;

    assign imem_en   = issue;
    assign imem_addr = pc_q;

    assign out_valid = (hold_valid | inflight_q) & ~redirect_accept;
    assign out_instr = hold_valid ? hold_instr : imem_rdata;
    assign out_pc    = hold_valid ? hold_pc    : inflight_pc_q;
    assign out_op    = out_instr[OP_LSB +: OP_W];
    assign out_funct = out_instr[FUNCT_W-1:0];
    assign misalign  = misalign_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
                if (redirect_accept) begin
                    pc_d = redirect_pc;
                end
            end
            RUN: begin
                if (redirect_accept) begin
                    pc_d       = redirect_pc;
                    inflight_d = 1'b0;
                end else if (issue) begin
                    pc_d          = pc_q + STEP_V;
                    inflight_d    = 1'b1;
                    inflight_pc_d = pc_q;
                end else begin
                    // Response was either consumed or moved into the skid this cycle.
                    inflight_d = 1'b0;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            misalign_q    <= redirect_valid & ~aligned;
        end
    end

    ifetch_skid #(
        .ADDR_W (ADDR_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .drain      (skid_drain),
        .flush      (redirect_accept),
        .in_instr   (imem_rdata),
        .in_pc      (inflight_pc_q),
        .hold_valid (hold_valid),
        .hold_instr (hold_instr),
        .hold_pc    (hold_pc)
    );

endmodule

// File: tb/tb_ifetch_stream.sv
// Scoreboard bench for ifetch_stream: expected PC stream kept as a queue of addresses,
// plus two small instances for address wrap and an 8-byte step.
module tb_ifetch_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance: ADDR_W=32, RESET_PC=0, STEP=4
    logic        rst;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [5:0]  out_op;
    logic [5:0]  out_funct;
    logic        misalign;

    // wrap instance: ADDR_W=8, RESET_PC=0xF8, STEP=4
    logic        rst_b;
    logic        imem_en1;
    logic [7:0]  imem_addr1;
    logic [31:0] imem_rdata1;
    logic        redirect_valid1;
    logic [7:0]  redirect_pc1;
    logic        out_valid1;
    logic        out_ready1;
    logic [31:0] out_instr1;
    logic [7:0]  out_pc1;
    logic [5:0]  out_op1;
    logic [5:0]  out_funct1;
    logic        misalign1;

    // step-8 instance: ADDR_W=32, RESET_PC=0, STEP=8
    logic        imem_en2;
    logic [31:0] imem_addr2;
    logic [31:0] imem_rdata2;
    logic        redirect_valid2;
    logic [31:0] redirect_pc2;
    logic        out_valid2;
    logic        out_ready2;
    logic [31:0] out_instr2;
    logic [31:0] out_pc2;
    logic [5:0]  out_op2;
    logic [5:0]  out_funct2;
    logic        misalign2;

    ifetch_stream dut (
        .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .out_op(out_op),
        .out_funct(out_funct), .misalign(misalign)
    );

    ifetch_stream #(.ADDR_W(8), .RESET_PC(8'hF8), .STEP(4)) dut_wrap (
        .clk(clk), .rst(rst_b), .imem_en(imem_en1), .imem_addr(imem_addr1), .imem_rdata(imem_rdata1),
        .redirect_valid(redirect_valid1), .redirect_pc(redirect_pc1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_instr(out_instr1), .out_pc(out_pc1), .out_op(out_op1),
        .out_funct(out_funct1), .misalign(misalign1)
    );

    ifetch_stream #(.ADDR_W(32), .RESET_PC(32'h0), .STEP(8)) dut_s8 (
        .clk(clk), .rst(rst_b), .imem_en(imem_en2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_instr(out_instr2), .out_pc(out_pc2), .out_op(out_op2),
        .out_funct(out_funct2), .misalign(misalign2)
    );

    // ROM contents: a scrambled function of the address so op/funct fields vary.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_1234;
    endfunction

    always @(posedge clk) begin
        if (imem_en)  imem_rdata  <= rom(imem_addr);
        if (imem_en1) imem_rdata1 <= rom(32'(imem_addr1));
        if (imem_en2) imem_rdata2 <= rom(imem_addr2);
    end

    int passes = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic chk_b(input string nm, input logic act, input logic exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference model: the ordered addresses the consumer should accept next.
    logic [31:0] exp_q[$];
    logic [31:0] next_pc;
    bit          mon_en = 1'b0;
    int          n_acc  = 0;

    task automatic refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back(next_pc);
            next_pc = next_pc + 32'd4;
        end
    endtask

    task automatic restart(input logic [31:0] start);
        exp_q.delete();
        next_pc = start;
        refill();
    endtask

    task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc);
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (rv && (rpc % 4 == 0)) restart(rpc);
        refill();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the model on each handshake and checks timing properties.
    initial begin
        logic        r1, r2, prev_stall, prev_mis, racc;
        logic [31:0] r_tgt, prev_pc, prev_instr, e, w;
        int          idle;
        r1 = 0; r2 = 0; prev_stall = 0; prev_mis = 0; idle = 0;
        r_tgt = '0; prev_pc = '0; prev_instr = '0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                r1 = 0; r2 = 0; prev_stall = 0; prev_mis = 0; idle = 0;
            end else begin
                racc = redirect_valid && (redirect_pc % 4 == 0);
                chk_b("misalign_pulse", misalign, prev_mis);
                if (racc) begin
                    chk_b("redir_same_cycle_valid", out_valid, 1'b0);
                end else if (r1) begin
                    chk_b("redir_gap_valid", out_valid, 1'b0);
                    chk_b("redir_fetch_en", imem_en, 1'b1);
                    chk("redir_fetch_addr", imem_addr, r_tgt);
                end else if (r2) begin
                    chk_b("redir_arrive_valid", out_valid, 1'b1);
                    chk("redir_arrive_pc", out_pc, r_tgt);
                end
                if (prev_stall && !racc) begin
                    chk_b("stall_valid", out_valid, 1'b1);
                    chk("stall_pc", out_pc, prev_pc);
                    chk("stall_instr", out_instr, prev_instr);
                end
                if (out_valid && out_ready) begin
                    n_acc++;
                    idle = 0;
                    if (exp_q.size() == 0) begin
                        chk("sb_depth", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        w = rom(e);
                        chk("out_pc", out_pc, e);
                        chk("out_instr", out_instr, w);
                        chk("out_op", 32'(out_op), 32'(w[31:26]));
                        chk("out_funct", 32'(out_funct), 32'(w[5:0]));
                    end
                end else if (out_ready && !racc && !r1) begin
                    idle++;
                    if (idle > 1) begin
                        chk("stream_gap_cycles", 32'(idle), 32'd1);
                        idle = 0;
                    end
                end
                prev_mis   = redirect_valid && (redirect_pc % 4 != 0);
                r2         = r1 && !racc;
                r1         = racc;
                if (racc) r_tgt = redirect_pc;
                prev_stall = out_valid && !out_ready;
                prev_pc    = out_pc;
                prev_instr = out_instr;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    localparam logic [7:0] WRAP_EXP [4] = '{8'hF8, 8'hFC, 8'h00, 8'h04};

    initial begin
        int n1, n2;
        rst = 1'b0; rst_b = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        redirect_valid1 = 1'b0; redirect_pc1 = '0; out_ready1 = 1'b1;
        redirect_valid2 = 1'b0; redirect_pc2 = '0; out_ready2 = 1'b1;

        // reset values without any clock edge
        #1;
        chk_b("reset_imem_en", imem_en, 1'b0);
        chk_b("reset_out_valid", out_valid, 1'b0);
        chk_b("reset_misalign", misalign, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk_b("in_reset_imem_en", imem_en, 1'b0);
            chk_b("in_reset_out_valid", out_valid, 1'b0);
        end

        restart(32'h0);
        rst = 1'b1; rst_b = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        chk_b("boot_first_en", imem_en, 1'b1);
        chk("boot_first_addr", imem_addr, 32'h0);

        // boot stream; also exercises the wrap and step-8 instances
        n1 = 0; n2 = 0;
        for (int c = 0; c < 10; c++) begin
            out_ready = 1'b1;
            redirect_valid2 = (c == 3);
            redirect_pc2    = 32'h44;
            refill();
            @(negedge clk);
            if (out_valid1) begin
                if (n1 < 4) chk("wrap_pc", 32'(out_pc1), 32'(WRAP_EXP[n1]));
                chk("wrap_instr", out_instr1, rom(32'(out_pc1)));
                chk("wrap_fields", {20'b0, out_op1, out_funct1}, {20'b0, out_instr1[31:26], out_instr1[5:0]});
                n1++;
            end
            if (out_valid2) begin
                chk("s8_pc", out_pc2, 32'(n2 * 8));
                chk("s8_instr", out_instr2, rom(out_pc2));
                chk("s8_fields", {20'b0, out_op2, out_funct2}, {20'b0, out_instr2[31:26], out_instr2[5:0]});
                n2++;
            end
            chk_b("s8_misalign", misalign2, c == 4);
            chk_b("wrap_misalign", misalign1, 1'b0);
            @(posedge clk); #1;
        end
        redirect_valid2 = 1'b0;
        chk("wrap_count", 32'(n1), 32'd9);
        chk("s8_count", 32'(n2), 32'd9);

        // directed stall: no issue while stalled, one issue on release
        for (int i = 0; i < 3; i++) begin
            out_ready = 1'b0;
            refill();
            #1;
            chk_b("stall_no_issue", imem_en, 1'b0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk_b("stall_release_issue", imem_en, 1'b1);
        @(posedge clk); #1;
        repeat (4) step(1'b1, 1'b0, 32'h0);

        // directed aligned redirect, then misaligned one
        step(1'b1, 1'b1, 32'h40);
        repeat (4) step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h42);
        repeat (4) step(1'b1, 1'b0, 32'h0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] rpc;
            bit rdy, rv;
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 15) == 0);
            rpc = 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) != 0) rpc = rpc & ~32'h3;
            step(rdy, rv, rpc);
        end

        // async reset while a word sits in the hold register
        repeat (3) step(1'b1, 1'b0, 32'h0);
        repeat (2) step(1'b0, 1'b0, 32'h0);
        #2;
        rst = 1'b0;
        mon_en = 1'b0;
        #1;
        chk_b("async_rst_out_valid", out_valid, 1'b0);
        chk_b("async_rst_imem_en", imem_en, 1'b0);
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        redirect_valid = 1'b0;
        restart(32'h0);
        rst = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        chk_b("restart_en", imem_en, 1'b1);
        chk("restart_addr", imem_addr, 32'h0);
        repeat (8) step(1'b1, 1'b0, 32'h0);

        chk_b("enough_accepted", n_acc > 500, 1'b1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
